// File: rtl/cosine_arb_pkg.sv
// Shared types and constants for the cosine arbiter and its cosine pipeline.
package cosine_arb_pkg;

    // Default depth of the cosine pipeline in enabled clock edges.
    localparam int LATENCY_DEFAULT = 4;

    // IEEE-754 single-precision operand width.
    localparam int ANGLE_W = 32;

    // Requester identifiers carried in the tag pipeline.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Ownership tag travelling alongside each operation in the pipeline.
    typedef struct packed {
        logic v;
        logic id;
    } tag_t;

endpackage

// File: rtl/cosine.sv
// Four-stage pipelined single-precision cosine built on a rotation-mode CORDIC.
// Angle domain is [-pi, pi]; larger magnitudes are clamped to pi.
module cosine
    import cosine_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic [ANGLE_W-1:0] angle,
    output logic [ANGLE_W-1:0] result
);

    // Fixed point is Q2.30 throughout: one sign bit, one integer bit.
    localparam int FX_W       = 32;
    localparam int ITERS      = 24;
    localparam int HALF_ITERS = 12;

    localparam logic [33:0] PI_FX      = 34'd3373259426;
    localparam logic [33:0] HALF_PI_FX = 34'd1686629713;
    localparam logic signed [FX_W-1:0] CORDIC_K = 32'sd652032874;

    // atan(2^-i) in Q2.30.
    function automatic logic signed [FX_W-1:0] atan_tab(input int i);
        case (i)
            0:       atan_tab = 32'sd843314857;
            1:       atan_tab = 32'sd497837829;
            2:       atan_tab = 32'sd263043837;
            3:       atan_tab = 32'sd133525159;
            4:       atan_tab = 32'sd67021687;
            5:       atan_tab = 32'sd33543516;
            6:       atan_tab = 32'sd16775851;
            7:       atan_tab = 32'sd8388437;
            8:       atan_tab = 32'sd4194283;
            9:       atan_tab = 32'sd2097149;
            10:      atan_tab = 32'sd1048576;
            11:      atan_tab = 32'sd524288;
            12:      atan_tab = 32'sd262144;
            13:      atan_tab = 32'sd131072;
            14:      atan_tab = 32'sd65536;
            15:      atan_tab = 32'sd32768;
            16:      atan_tab = 32'sd16384;
            17:      atan_tab = 32'sd8192;
            18:      atan_tab = 32'sd4096;
            19:      atan_tab = 32'sd2048;
            20:      atan_tab = 32'sd1024;
            21:      atan_tab = 32'sd512;
            22:      atan_tab = 32'sd256;
            23:      atan_tab = 32'sd128;
            default: atan_tab = 32'sd0;
        endcase
    endfunction

    // |angle| in unsigned Q2.30 (34 bits so pi fits before clamping).
    function automatic logic [33:0] angle_mag(input logic [ANGLE_W-1:0] a);
        logic [7:0]  e;
        logic [33:0] m;
        e = a[30:23];
        m = {10'd0, 1'b1, a[22:0]};
        if (e == 8'd0)
            angle_mag = '0;
        else if (e > 8'd128)
            angle_mag = PI_FX;
        else if (e >= 8'd120)
            angle_mag = m << (e - 8'd120);
        else
            angle_mag = m >> (8'd120 - e);
    endfunction

    // Truncating Q2.30 to single-precision pack; non-positive values become zero.
    function automatic logic [ANGLE_W-1:0] fx_to_float(input logic signed [FX_W-1:0] x,
                                                      input logic neg);
        logic [FX_W-1:0] ux;
        logic [FX_W-1:0] norm;
        int              p;
        ux = x;
        p  = 0;
        for (int i = 0; i < FX_W - 1; i++) begin
            if (ux[i]) p = i;
        end
        norm = ux << (31 - p);
        if (x <= 0)
            fx_to_float = {neg, 31'd0};
        else
            fx_to_float = {neg, 8'(p + 97), norm[30:8]};
    endfunction

    logic [33:0]             mag_s1;
    logic signed [FX_W-1:0]  z_p1_d, z_p1_q;
    logic                    neg_p1_d, neg_p1_q;

    logic signed [FX_W-1:0]  x_s2, y_s2, z_s2;
    logic signed [FX_W-1:0]  x_p2_q, y_p2_q, z_p2_q;
    logic                    neg_p2_q;

    logic signed [FX_W-1:0]  x_s3, y_s3, z_s3;
    logic signed [FX_W-1:0]  x_p3_q;
    logic                    neg_p3_q;

    logic [ANGLE_W-1:0]      result_d, result_q;

    // ---- stage 1: float to fixed, fold into [0, pi/2] with a sign flag ----
    // Reduce the angle so the CORDIC only ever sees its convergent range.
    always_comb begin
        mag_s1 = angle_mag(angle);
        if (mag_s1 > PI_FX) mag_s1 = PI_FX;
        if (mag_s1 > HALF_PI_FX) begin
            mag_s1   = PI_FX - mag_s1;
            neg_p1_d = 1'b1;
        end else begin
            neg_p1_d = 1'b0;
        end
        z_p1_d = mag_s1[31:0];
    end

    // ---- stage 2: CORDIC iterations 0..11 ----
    // First half of the rotation, starting from the gain-compensated unit vector.
    always_comb begin
        x_s2 = CORDIC_K;
        y_s2 = '0;
        z_s2 = z_p1_q;
        for (int i = 0; i < HALF_ITERS; i++) begin
            if (z_s2 >= 0) begin
                x_s2 = x_s2 - (y_s2 >>> i);
                y_s2 = y_s2 + ((x_s2 + (y_s2 >>> i)) >>> i);
                z_s2 = z_s2 - atan_tab(i);
            end else begin
                x_s2 = x_s2 + (y_s2 >>> i);
                y_s2 = y_s2 - ((x_s2 - (y_s2 >>> i)) >>> i);
                z_s2 = z_s2 + atan_tab(i);
            end
        end
    end

    // ---- stage 3: CORDIC iterations 12..23 ----
    // Second half of the rotation; only the cosine (x) leg is kept.
    always_comb begin
        x_s3 = x_p2_q;
        y_s3 = y_p2_q;
        z_s3 = z_p2_q;
        for (int i = HALF_ITERS; i < ITERS; i++) begin
            if (z_s3 >= 0) begin
                x_s3 = x_s3 - (y_s3 >>> i);
                y_s3 = y_s3 + ((x_s3 + (y_s3 >>> i)) >>> i);
                z_s3 = z_s3 - atan_tab(i);
            end else begin
                x_s3 = x_s3 + (y_s3 >>> i);
                y_s3 = y_s3 - ((x_s3 - (y_s3 >>> i)) >>> i);
                z_s3 = z_s3 + atan_tab(i);
            end
        end
    end

    // ---- stage 4: fixed to float ----
    // Pack the cosine magnitude with the sign from the range fold.
    always_comb begin
        result_d = fx_to_float(x_p3_q, neg_p3_q);
    end

    // Datapath stage registers; they only move when the pipeline is enabled.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            z_p1_q   <= z_p1_d;
            neg_p1_q <= neg_p1_d;
            x_p2_q   <= x_s2;
            y_p2_q   <= y_s2;
            z_p2_q   <= z_s2;
            neg_p2_q <= neg_p1_q;
            x_p3_q   <= x_s3;
            neg_p3_q <= neg_p2_q;
        end
    end

    // Output register cleared on reset so the result port never shows stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            result_q <= '0;
        else if (clk_en)
            result_q <= result_d;
    end

    assign result = result_q;

endmodule

// File: rtl/cosine_arbiter.sv
// Two-requester round-robin front end sharing one pipelined cosine unit.
// Each operation carries an owner tag; an undeliverable result stalls everything.
module cosine_arbiter
    import cosine_arb_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [ANGLE_W-1:0] req0_angle,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [ANGLE_W-1:0] req1_angle,
    output logic               req1_ready,
    output logic               rsp0_valid,
    output logic [ANGLE_W-1:0] rsp0_result,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    output logic [ANGLE_W-1:0] rsp1_result,
    input  logic               rsp1_ready,
    output logic               busy
);

    tag_t               tag_q [LATENCY];
    tag_t               tag_d [LATENCY];
    logic               last_grant_q, last_grant_d;

    logic               out_v;
    logic               out_id;
    logic               stall;
    logic               cos_en;
    logic               cos_rst;
    logic               grant;
    logic               issue;
    logic [ANGLE_W-1:0] cos_angle;
    logic [ANGLE_W-1:0] cos_result;

    // The last tag stage lines up with the cosine result register.
    assign out_v   = tag_q[LATENCY-1].v;
    assign out_id  = tag_q[LATENCY-1].id;
    assign cos_rst = ~reset;

    // Stall when the owner of the presented result is not taking it.
    always_comb begin
        stall  = out_v & ~((out_id == REQ1) ? rsp1_ready : rsp0_ready);
        cos_en = ~stall;
    end

    // Two-way round robin: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = ~last_grant_q;
        if (req0_valid & ~req1_valid)
            grant = REQ0;
        else if (req1_valid & ~req0_valid)
            grant = REQ1;
        req0_ready = (grant == REQ0) & ~stall;
        req1_ready = (grant == REQ1) & ~stall;
    end

    // Issue the granted angle or inject a zero bubble, and shift the tags in lockstep.
    always_comb begin
        issue = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        if (issue)
            cos_angle = (grant == REQ1) ? req1_angle : req0_angle;
        else
            cos_angle = '0;

        last_grant_d = last_grant_q;
        for (int i = 0; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i];
        end
        if (cos_en) begin
            tag_d[0].v  = issue;
            tag_d[0].id = issue ? grant : REQ0;
            for (int i = 1; i < LATENCY; i++) begin
                tag_d[i] = tag_q[i-1];
            end
            if (issue) last_grant_d = grant;
        end
    end

    // Tag pipeline and grant history; reset drops every in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= REQ1;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Route the result to its owner; the other port sees zero.
    always_comb begin
        rsp0_valid  = out_v & (out_id == REQ0);
        rsp1_valid  = out_v & (out_id == REQ1);
        rsp0_result = rsp0_valid ? cos_result : '0;
        rsp1_result = rsp1_valid ? cos_result : '0;
    end

    // Busy while any stage holds a live operation.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | tag_q[i].v;
        end
    end

    cosine u_cosine (
        .clk    (clk),
        .reset  (cos_rst),
        .clk_en (cos_en),
        .angle  (cos_angle),
        .result (cos_result)
    );

endmodule

// File: tb/tb_cosine_arbiter.sv
// Directed bench for cosine_arbiter: grant order, latency, stall, ownership, reset.
module tb_cosine_arbiter;

    localparam int TOL = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_angle = '0, req1_angle = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic        busy;

    typedef struct {
        logic        id;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_iss = 0;
    int   n_del0 = 0;
    int   n_del1 = 0;

    cosine_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_angle  (req0_angle),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_angle  (req1_angle),
        .req1_ready  (req1_ready),
        .rsp0_valid  (rsp0_valid),
        .rsp0_result (rsp0_result),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_result (rsp1_result),
        .rsp1_ready  (rsp1_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Hand-computed cosines of the angles used below.
    function automatic logic [31:0] cos_of(input logic [31:0] a);
        case (a)
            32'h3F800000: cos_of = 32'h3F0A5140;
            32'hBF800000: cos_of = 32'h3F0A5140;
            32'h00000000: cos_of = 32'h3F800000;
            32'h3F000000: cos_of = 32'h3F60A940;
            default:      cos_of = 32'hFFFFFFFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] want);
        logic [31:0] d;
        d = (obs > want) ? obs - want : want - obs;
        total++;
        assert (d <= 32'(TOL)) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (+-%0d)", tag, obs, want, TOL);
        end
    endtask

    // One clock: check any presented response against the model, log issues, advance.
    task automatic cyc();
        logic r1;
        #1;
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
            if (exp_q.size() != 0) begin
                r1 = rsp1_valid;
                chk("rsp_owner", 32'(r1), 32'(exp_q[0].id));
                chk_near("rsp_result", r1 ? rsp1_result : rsp0_result, exp_q[0].res);
                chk("rsp_other_zero", r1 ? rsp0_result : rsp1_result, 32'd0);
                if (r1 && rsp1_ready) begin
                    void'(exp_q.pop_front());
                    n_del1++;
                end else if (!r1 && rsp0_ready) begin
                    void'(exp_q.pop_front());
                    n_del0++;
                end
            end
        end
        if (req0_valid && req0_ready) begin
            exp_q.push_back('{1'b0, cos_of(req0_angle)});
            n_iss++;
        end
        if (req1_valid && req1_ready) begin
            exp_q.push_back('{1'b1, cos_of(req1_angle)});
            n_iss++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_no_loss"}, 32'(n_del0 + n_del1), 32'(n_iss));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base0, base1, baseiss, n;
        logic [31:0] held;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_rsp1_result", rsp1_result, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ---- tie: grants alternate starting with requester 0, one result per cycle ----
        req0_angle = 32'h00000000;
        req1_angle = 32'h3F000000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("tie_req0_ready", 32'(req0_ready), 32'(i % 2 == 0));
            chk("tie_req1_ready", 32'(req1_ready), 32'(i % 2 == 1));
            if (i >= 4) chk("tie_throughput", 32'(rsp0_valid | rsp1_valid), 32'd1);
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain("tie");
        chk("tie_count0", 32'(n_del0), 32'd5);
        chk("tie_count1", 32'(n_del1), 32'd5);

        // ---- single request: latency, routing, then idle bubbles ----
        base0 = n_del0;
        base1 = n_del1;
        req0_angle = 32'h3F800000;
        req0_valid = 1'b1;
        #1;
        chk("single_req0_ready", 32'(req0_ready), 32'd1);
        chk("single_req1_ready", 32'(req1_ready), 32'd0);
        cyc();
        req0_valid = 1'b0;
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_lat1", 32'(rsp0_valid), 32'd0);
        cyc();
        chk("single_lat2", 32'(rsp0_valid), 32'd0);
        cyc();
        chk("single_lat3", 32'(rsp0_valid), 32'd0);
        cyc();
        chk("single_lat4", 32'(rsp0_valid), 32'd1);
        chk("single_rsp1_low", 32'(rsp1_valid), 32'd0);
        chk_near("single_result", rsp0_result, 32'h3F0A5140);
        cyc();
        chk("single_delivered", 32'(rsp0_valid), 32'd0);
        chk("single_busy_fell", 32'(busy), 32'd0);
        repeat (10) cyc();
        chk("single_one_rsp0", 32'(n_del0 - base0), 32'd1);
        chk("single_no_rsp1", 32'(n_del1 - base1), 32'd0);

        // ---- mixed ownership 0,0,1,0 ----
        base0 = n_del0;
        base1 = n_del1;
        baseiss = n_iss;
        req0_valid = 1'b1;
        req0_angle = 32'h3F800000;
        cyc();
        req0_angle = 32'h00000000;
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_angle = 32'h3F000000;
        cyc();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_angle = 32'hBF800000;
        cyc();
        req0_valid = 1'b0;
        chk("mixed_issued", 32'(n_iss - baseiss), 32'd4);
        drain("mixed");
        chk("mixed_count0", 32'(n_del0 - base0), 32'd3);
        chk("mixed_count1", 32'(n_del1 - base1), 32'd1);

        // ---- back-pressure: requester 0 holds off its result for 5 cycles ----
        base0 = n_del0;
        base1 = n_del1;
        baseiss = n_iss;
        rsp0_ready = 1'b0;
        req0_angle = 32'h3F800000;
        req1_angle = 32'h3F000000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        while (!rsp0_valid && n < 12) begin
            cyc();
            n++;
        end
        chk("bp_reached", 32'(rsp0_valid), 32'd1);
        held = rsp0_result;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 32'(rsp0_valid), 32'd1);
            chk("bp_result_stable", rsp0_result, held);
            chk("bp_cos_en", 32'(dut.cos_en), 32'd0);
            chk("bp_req0_ready", 32'(req0_ready), 32'd0);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        drain("bp");
        chk("bp_delivered", 32'((n_del0 - base0) + (n_del1 - base1)), 32'(n_iss - baseiss));

        // ---- reset mid-flight: three ops dropped, then a fresh request works ----
        req0_angle = 32'h3F800000;
        req0_valid = 1'b1;
        repeat (3) cyc();
        req0_valid = 1'b0;
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy_cleared", 32'(busy), 32'd0);
        chk("mid_rsp0_low", 32'(rsp0_valid), 32'd0);
        chk("mid_rsp1_low", 32'(rsp1_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        n_iss = n_del0 + n_del1;
        base0 = n_del0;
        repeat (8) cyc();
        chk("mid_quiet_busy", 32'(busy), 32'd0);
        chk("mid_quiet_none", 32'(n_del0 - base0), 32'd0);
        req0_angle = 32'hBF800000;
        req0_valid = 1'b1;
        cyc();
        req0_valid = 1'b0;
        drain("mid");
        chk("mid_retry_rsp", 32'(n_del0 - base0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
